// File: rtl/ms_feeder_pkg.sv
// Shared types and helpers for the multiplier-switch feeder.
// Holds the FSM encoding, default sizing and lane-slice helpers.
package ms_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int DEF_NUM_MS       = 8;
    localparam int DEF_IN_DATA_TYPE = 16;
    localparam int DEF_LEN_W        = 8;
    localparam int DEF_MULT_LAT     = 2;

    function automatic int lane_lo(input int k, input int w);
        return k * w;
    endfunction

    // Drain counter must reach MULT_LAT, i.e. hold MULT_LAT+1 distinct values.
    function automatic int drain_w(input int lat);
        return $clog2(lat + 2);
    endfunction

endpackage

// File: rtl/ms_lane_drive.sv
// One switch lane: registered valid, stationary and data.
// Data only updates on a load; valid/stationary re-evaluate every cycle.
module ms_lane_drive #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_stat_sel,
    input  logic         i_en,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic         o_stationary,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic         r_stat;
    logic [W-1:0] r_data;

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_stat  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= i_load & i_en;
            r_stat  <= i_load & i_en & i_stat_sel;
            if (i_load) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid      = r_valid;
    assign o_stationary = r_stat;
    assign o_data       = r_data;

endmodule

// File: rtl/ms_feeder.sv
// Job sequencer feeding a row of multiplier switches:
// one stationary beat, N streaming beats, then a fixed drain.
module ms_feeder
    import ms_feeder_pkg::*;
#(
    parameter int NUM_MS       = DEF_NUM_MS,
    parameter int IN_DATA_TYPE = DEF_IN_DATA_TYPE,
    parameter int LEN_W        = DEF_LEN_W,
    parameter int MULT_LAT     = DEF_MULT_LAT
) (
    input  logic                           CLK,
    input  logic                           rst,
    input  logic                           i_start,
    input  logic [LEN_W-1:0]               i_num_stream,
    input  logic [NUM_MS-1:0]              i_ms_mask,
    input  logic                           i_src_valid,
    input  logic [NUM_MS*IN_DATA_TYPE-1:0] i_src_data,
    output logic                           o_src_ready,
    output logic [NUM_MS-1:0]              o_ms_valid,
    output logic [NUM_MS*IN_DATA_TYPE-1:0] o_ms_data,
    output logic [NUM_MS-1:0]              o_ms_stationary,
    output logic                           o_busy,
    output logic                           o_done
);

    localparam int DW = drain_w(MULT_LAT);

    state_t              r_state;
    logic [LEN_W-1:0]    r_num;
    logic [LEN_W-1:0]    r_cnt;
    logic [NUM_MS-1:0]   r_mask;
    logic [DW-1:0]       r_drain;
    logic                r_busy;
    logic                r_done;

    logic                w_ready;
    logic                w_xfer;
    logic                w_stat_sel;
    logic [LEN_W-1:0]    w_cnt_nxt;
    logic                w_last;

    always_comb begin
        w_ready    = (r_state == ST_LOAD) || (r_state == ST_STREAM);
        w_xfer     = i_src_valid && w_ready;
        w_stat_sel = (r_state == ST_LOAD);
        w_cnt_nxt  = r_cnt + 1'b1;
        w_last     = (w_cnt_nxt == r_num);
    end

    // r_cnt never exceeds r_num, so w_cnt_nxt cannot wrap before w_last fires.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_num   <= '0;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_LOAD;
                        r_num   <= i_num_stream;
                        r_mask  <= i_ms_mask;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_xfer) begin
                        r_drain <= '0;
                        if (r_num == '0) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_state <= ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_xfer) begin
                        r_cnt <= w_cnt_nxt;
                        if (w_last) begin
                            r_state <= ST_DRAIN;
                            r_drain <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == DW'(MULT_LAT)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_MS; k++) begin : g_lane
        ms_lane_drive #(
            .W(IN_DATA_TYPE)
        ) u_lane (
            .CLK         (CLK),
            .rst         (rst),
            .i_load      (w_xfer),
            .i_stat_sel  (w_stat_sel),
            .i_en        (r_mask[k]),
            .i_data      (i_src_data[lane_lo(k, IN_DATA_TYPE) +: IN_DATA_TYPE]),
            .o_valid     (o_ms_valid[k]),
            .o_stationary(o_ms_stationary[k]),
            .o_data      (o_ms_data[lane_lo(k, IN_DATA_TYPE) +: IN_DATA_TYPE])
        );
    end

    assign o_src_ready = w_ready;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_ms_feeder.sv
// Directed bench for ms_feeder with a job-level reference model.
// The model tracks beats taken and cycles since the last beat.
module tb_ms_feeder;

    localparam int NMS = 8;
    localparam int W   = 16;
    localparam int LW  = 8;
    localparam int L   = 2;
    localparam int DWD = NMS * W;

    logic           CLK = 1'b0;
    logic           rst;
    logic           i_start;
    logic [LW-1:0]  i_num_stream;
    logic [NMS-1:0] i_ms_mask;
    logic           i_src_valid;
    logic [DWD-1:0] i_src_data;
    logic           o_src_ready;
    logic [NMS-1:0] o_ms_valid;
    logic [DWD-1:0] o_ms_data;
    logic [NMS-1:0] o_ms_stationary;
    logic           o_busy;
    logic           o_done;

    ms_feeder #(
        .NUM_MS      (NMS),
        .IN_DATA_TYPE(W),
        .LEN_W       (LW),
        .MULT_LAT    (L)
    ) dut (
        .CLK            (CLK),
        .rst            (rst),
        .i_start        (i_start),
        .i_num_stream   (i_num_stream),
        .i_ms_mask      (i_ms_mask),
        .i_src_valid    (i_src_valid),
        .i_src_data     (i_src_data),
        .o_src_ready    (o_src_ready),
        .o_ms_valid     (o_ms_valid),
        .o_ms_data      (o_ms_data),
        .o_ms_stationary(o_ms_stationary),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DWD-1:0] act,
                       input logic [DWD-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model state (job level, not an FSM mirror)
    bit             chk_en = 1'b0;
    bit             m_active = 1'b0;
    bit             m_x;
    int             m_taken = 0;
    int             m_need = 0;
    int             m_post = 0;
    logic [NMS-1:0] m_mask = '0;
    logic [NMS-1:0] e_valid = '0;
    logic [NMS-1:0] e_stat = '0;
    logic [DWD-1:0] e_data = '0;
    logic           e_busy = 1'b0;
    logic           e_done = 1'b0;

    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                chk("valid", DWD'(o_ms_valid), DWD'(e_valid));
                chk("stat", DWD'(o_ms_stationary), DWD'(e_stat));
                chk("data", o_ms_data, e_data);
                chk("busy", DWD'(o_busy), DWD'(e_busy));
                chk("done", DWD'(o_done), DWD'(e_done));
                chk("ready", DWD'(o_src_ready),
                    DWD'(m_active && m_taken < m_need));
            end
            if (rst) begin
                m_active = 1'b0;
                m_taken  = 0;
                m_need   = 0;
                m_post   = 0;
                e_valid  = '0;
                e_stat   = '0;
                e_data   = '0;
                e_busy   = 1'b0;
                e_done   = 1'b0;
            end else begin
                m_x = m_active && m_taken < m_need && i_src_valid;
                e_valid = m_x ? m_mask : '0;
                e_stat  = (m_x && m_taken == 0) ? m_mask : '0;
                if (m_x) e_data = i_src_data;
                e_done = 1'b0;
                if (!m_active) begin
                    if (i_start) begin
                        m_active = 1'b1;
                        m_need   = int'(i_num_stream) + 1;
                        m_mask   = i_ms_mask;
                        m_taken  = 0;
                        m_post   = 0;
                    end
                end else if (m_taken < m_need) begin
                    if (m_x) begin
                        m_taken++;
                        if (m_taken == m_need) m_post = 1;
                    end
                end else if (m_post == L + 2) begin
                    m_active = 1'b0;
                end else begin
                    m_post++;
                    e_done = (m_post == L + 2);
                end
                e_busy = m_active;
            end
        end
    end

    // Per-job observations
    int             j_done, j_beats, j_firstx, j_nv, j_fv, j_lv;
    logic [NMS-1:0] j_or_v, j_or_s;
    int             j_lane [NMS];
    logic [NMS-1:0] j_v [300];
    logic [NMS-1:0] j_s [300];

    task automatic run_job(input logic [NMS-1:0] mask, input int n,
                           input int stall_at, input int stall_len,
                           input int pulse_at);
        j_done = -1; j_beats = 0; j_firstx = -1;
        j_nv = 0; j_fv = -1; j_lv = -1;
        j_or_v = '0; j_or_s = '0;
        for (int l = 0; l < NMS; l++) j_lane[l] = 0;
        i_ms_mask = mask;
        i_num_stream = LW'(n);
        for (int k = 0; k < 300; k++) begin
            i_start = (k == 0) || (k == pulse_at);
            i_src_valid = !(k >= stall_at && k < stall_at + stall_len);
            for (int l = 0; l < NMS; l++)
                i_src_data[l*W +: W] = W'(k * 16 + l) ^ W'(16'hA500);
            @(negedge CLK);
            j_v[k] = o_ms_valid;
            j_s[k] = o_ms_stationary;
            if (o_src_ready && i_src_valid) begin
                j_beats++;
                if (j_firstx < 0) j_firstx = k;
            end
            j_or_v |= o_ms_valid;
            j_or_s |= o_ms_stationary;
            if (o_ms_valid != '0) begin
                j_nv++;
                if (j_fv < 0) j_fv = k;
                j_lv = k;
            end
            for (int l = 0; l < NMS; l++)
                if (o_ms_valid[l] && !o_ms_stationary[l]) j_lane[l]++;
            if (o_done) j_done = k;
            @(posedge CLK);
            #1;
            if (j_done >= 0) break;
        end
        i_start = 1'b0;
        i_src_valid = 1'b0;
        if (j_done < 0) begin
            checks++;
            errors++;
            $display("FAIL job_timeout got no done want done");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        i_num_stream = '0;
        i_ms_mask = '0;
        i_src_valid = 1'b0;
        i_src_data = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_valid", DWD'(o_ms_valid), '0);
        chk("rst_stat", DWD'(o_ms_stationary), '0);
        chk("rst_data", o_ms_data, '0);
        chk("rst_busy", DWD'(o_busy), '0);
        chk("rst_done", DWD'(o_done), '0);
        chk("rst_ready", DWD'(o_src_ready), '0);
        chk_en = 1'b1;
        @(posedge CLK);
        #1;
        rst = 1'b0;

        // Full mask, three stream beats, unstalled
        run_job(8'hFF, 3, -1, 0, -1);
        chk("A_stat2", DWD'(j_s[2]), DWD'(8'hFF));
        chk("A_val2", DWD'(j_v[2]), DWD'(8'hFF));
        for (int k = 3; k <= 5; k++) begin
            chk("A_valS", DWD'(j_v[k]), DWD'(8'hFF));
            chk("A_statS", DWD'(j_s[k]), '0);
        end
        chk("A_val6", DWD'(j_v[6]), '0);
        chk("A_done", DWD'(j_done), DWD'(8));
        chk("A_beats", DWD'(j_beats), DWD'(4));

        // Sparse mask
        run_job(8'hA5, 2, -1, 0, -1);
        chk("B_or_v", DWD'(j_or_v), DWD'(8'hA5));
        chk("B_or_s", DWD'(j_or_s), DWD'(8'hA5));
        for (int l = 0; l < NMS; l++)
            chk("B_lane", DWD'(j_lane[l]), DWD'((l == 0 || l == 2 ||
                l == 5 || l == 7) ? 2 : 0));
        chk("B_done", DWD'(j_done), DWD'(7));

        // Stationary-only job
        run_job(8'h3C, 0, -1, 0, -1);
        chk("C_beats", DWD'(j_beats), DWD'(1));
        chk("C_nv", DWD'(j_nv), DWD'(1));
        chk("C_or_s", DWD'(j_or_s), DWD'(8'h3C));
        chk("C_lat", DWD'(j_done - j_firstx), DWD'(L + 2));
        chk("C_done", DWD'(j_done), DWD'(5));

        // Two-cycle source stall plus a stray start mid-job
        run_job(8'hFF, 4, 4, 2, 3);
        chk("D_beats", DWD'(j_beats), DWD'(5));
        chk("D_bubble", DWD'((j_lv - j_fv + 1) - j_nv), DWD'(2));
        chk("D_done", DWD'(j_done), DWD'(11));
        @(negedge CLK);
        chk("D_idle", DWD'(o_busy), '0);
        @(posedge CLK);
        #1;

        // Start held during the DONE cycle must be dropped
        run_job(8'h0F, 1, -1, 0, 6);
        chk("E_done", DWD'(j_done), DWD'(6));
        @(negedge CLK);
        chk("E_idle0", DWD'(o_busy), '0);
        @(negedge CLK);
        chk("E_idle1", DWD'(o_busy), '0);
        @(posedge CLK);
        #1;

        // Reset after the second stream beat of a 5-beat job
        i_ms_mask = 8'hFF;
        i_num_stream = LW'(5);
        i_src_valid = 1'b1;
        i_src_data = {NMS{16'h5A3C}};
        i_start = 1'b1;
        @(posedge CLK);
        #1;
        i_start = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        rst = 1'b1;
        @(posedge CLK);
        #1;
        rst = 1'b0;
        i_src_valid = 1'b0;
        @(negedge CLK);
        chk("R_valid", DWD'(o_ms_valid), '0);
        chk("R_stat", DWD'(o_ms_stationary), '0);
        chk("R_data", o_ms_data, '0);
        chk("R_busy", DWD'(o_busy), '0);
        chk("R_ready", DWD'(o_src_ready), '0);
        @(posedge CLK);
        #1;
        run_job(8'hFF, 2, -1, 0, -1);
        chk("R_done", DWD'(j_done), DWD'(7));
        chk("R_beats", DWD'(j_beats), DWD'(3));

        // Maximum stream length, no wrap
        run_job(8'h81, 255, -1, 0, -1);
        chk("M_beats", DWD'(j_beats), DWD'(256));
        chk("M_done", DWD'(j_done), DWD'(260));

        repeat (3) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
